// File: rtl/i2c_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : i2c_cmd_sequencer
// Description : Command FIFO, quarter-bit tick generator and single-command
//               issue/ACK sequencer in front of the I2C bit engine.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_cmd_sequencer #(
    parameter int CMD_DEPTH = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [DIV_WIDTH-1:0]         divisor,
    input  logic                         cmdValid,
    input  logic [1:0]                   cmdOp,
    input  logic [7:0]                   cmdData,
    output logic                         cmdReady,
    output logic [$clog2(CMD_DEPTH):0]   fifoCount,
    output logic [1:0]                   i2cCommand,
    output logic [7:0]                   i2cWriteData,
    output logic                         i2cTransactionValid,
    output logic                         cycleDone,
    input  logic                         i2cBusy,
    input  logic                         i2cWriteAck,
    input  logic                         i2cReadDataValid,
    input  logic [7:0]                   i2cReadData,
    output logic                         ackValid,
    output logic                         ackBit,
    output logic                         nackError,
    output logic                         opError,
    input  logic                         errorClear,
    output logic                         busy
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] OP_START   = 2'b00;
    localparam logic [1:0] OP_STOP    = 2'b01;
    localparam logic [1:0] OP_TX      = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(CMD_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT_HI  = 3'd2,
        S_WAIT_LO  = 3'd3,
        S_FLUSH    = 3'd4,
        S_WAIT_HI2 = 3'd5,
        S_WAIT_LO2 = 3'd6
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Quarter-bit tick generator
    // ------------------------------------------------------------------
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic                 w_tick;

    always_comb begin
        w_tick    = enable && (div_cnt_q >= divisor);
        div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        if (!enable || w_tick) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign cycleDone = w_tick;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [9:0]       fifo_mem_q [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic [1:0]       w_head_op;
    logic [7:0]       w_head_data;

    assign cmdReady    = (count_q != FULL_COUNT);
    assign fifoCount   = count_q;
    // A flush clock discards any push arriving on that same clock.
    assign w_push      = cmdValid && cmdReady && !w_flush;
    assign w_head_op   = fifo_mem_q[rd_ptr_q][9:8];
    assign w_head_data = fifo_mem_q[rd_ptr_q][7:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= {cmdOp, cmdData};
        end
    end

    // ------------------------------------------------------------------
    // Issue / ACK sequencer
    // ------------------------------------------------------------------
    logic w_accept;
    logic w_capture;
    logic w_set_op_err;
    logic nack_q, nack_d;
    logic w_nack_now;
    logic ack_valid_q, ack_bit_q, nack_err_q, op_err_q;

    assign w_accept   = w_tick && i2cTransactionValid && !i2cBusy;
    assign w_capture  = ((state_q == S_WAIT_LO) || (state_q == S_WAIT_LO2)) && i2cReadDataValid;
    // An ACK sample landing on the same clock busy falls still decides the flush.
    assign w_nack_now = w_capture ? i2cReadData[0] : nack_q;

    always_comb begin
        state_d             = state_q;
        nack_d              = nack_q;
        w_pop               = 1'b0;
        w_flush             = 1'b0;
        w_set_op_err        = 1'b0;
        i2cTransactionValid = 1'b0;
        i2cCommand          = OP_START;
        i2cWriteData        = 8'h00;
        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && enable) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_head_op == OP_ILLEGAL) begin
                    w_pop        = 1'b1;
                    w_set_op_err = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    i2cTransactionValid = 1'b1;
                    i2cCommand          = w_head_op;
                    i2cWriteData        = w_head_data;
                    if (w_tick && !i2cBusy) begin
                        w_pop   = 1'b1;
                        nack_d  = 1'b0;
                        state_d = S_WAIT_HI;
                    end
                end
            end
            S_WAIT_HI: begin
                if (i2cBusy) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (w_capture) begin
                    nack_d = i2cReadData[0];
                end
                if (!i2cBusy) begin
                    if (w_nack_now) begin
                        w_flush = 1'b1;
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                i2cTransactionValid = 1'b1;
                i2cCommand          = OP_STOP;
                if (w_tick && !i2cBusy) begin
                    state_d = S_WAIT_HI2;
                end
            end
            S_WAIT_HI2: begin
                if (i2cBusy) begin
                    state_d = S_WAIT_LO2;
                end
            end
            S_WAIT_LO2: begin
                if (!i2cBusy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            nack_q      <= 1'b0;
            ack_valid_q <= 1'b0;
            ack_bit_q   <= 1'b0;
            nack_err_q  <= 1'b0;
            op_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            nack_q      <= nack_d;
            ack_valid_q <= w_capture;
            if (w_capture) begin
                ack_bit_q <= i2cReadData[0];
            end
            if (w_capture && i2cReadData[0]) begin
                nack_err_q <= 1'b1;
            end else if (errorClear) begin
                nack_err_q <= 1'b0;
            end
            if (w_set_op_err) begin
                op_err_q <= 1'b1;
            end else if (errorClear) begin
                op_err_q <= 1'b0;
            end
        end
    end

    assign ackValid  = ack_valid_q;
    assign ackBit    = ack_bit_q;
    assign nackError = nack_err_q;
    assign opError   = op_err_q;
    assign busy      = (state_q != S_IDLE) || (count_q != '0);

    // Only the ACK bit of the engine read data is meaningful here.
    logic w_unused_inputs;
    assign w_unused_inputs = &{1'b0, i2cReadData[7:1], i2cWriteAck};

    a_write_ack_on_tx_accept: assert property (
        @(posedge clk) disable iff (reset)
        i2cWriteAck == (w_accept && (i2cCommand == OP_TX))
    );

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_i2c_cmd_sequencer
// Description : Directed self-checking bench with a small I2C engine model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] divisor;
    logic        cmdValid;
    logic [1:0]  cmdOp;
    logic [7:0]  cmdData;
    logic        cmdReady;
    logic [3:0]  fifoCount;
    logic [1:0]  i2cCommand;
    logic [7:0]  i2cWriteData;
    logic        i2cTransactionValid;
    logic        cycleDone;
    logic        i2cBusy;
    logic        i2cWriteAck;
    logic        i2cReadDataValid;
    logic [7:0]  i2cReadData;
    logic        ackValid;
    logic        ackBit;
    logic        nackError;
    logic        opError;
    logic        errorClear;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    i2c_cmd_sequencer #(.CMD_DEPTH(8), .DIV_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .divisor(divisor),
        .cmdValid(cmdValid), .cmdOp(cmdOp), .cmdData(cmdData),
        .cmdReady(cmdReady), .fifoCount(fifoCount),
        .i2cCommand(i2cCommand), .i2cWriteData(i2cWriteData),
        .i2cTransactionValid(i2cTransactionValid), .cycleDone(cycleDone),
        .i2cBusy(i2cBusy), .i2cWriteAck(i2cWriteAck),
        .i2cReadDataValid(i2cReadDataValid), .i2cReadData(i2cReadData),
        .ackValid(ackValid), .ackBit(ackBit), .nackError(nackError),
        .opError(opError), .errorClear(errorClear), .busy(busy)
    );

    // Engine model: acts on falling edges, the sequence drives on rising edge + 1.
    int         phase    = 0;
    int         hold     = 0;
    logic [1:0] cur_op   = 2'b00;
    int         log_n    = 0;
    logic [1:0] log_op   [256];
    logic [7:0] log_data [256];
    int         tx_seen  = 0;
    int         nack_idx = -1;
    int         ack_cnt  = 0;
    logic       last_ack = 1'b0;

    assign i2cWriteAck = cycleDone && i2cTransactionValid && !i2cBusy && (i2cCommand == 2'b10);

    initial begin
        i2cBusy          = 1'b0;
        i2cReadDataValid = 1'b0;
        i2cReadData      = 8'h00;
    end

    always @(negedge clk) begin
        if (reset) begin
            phase            = 0;
            hold             = 0;
            i2cBusy          = 1'b0;
            i2cReadDataValid = 1'b0;
            i2cReadData      = 8'h00;
        end else begin
            if (ackValid) begin
                ack_cnt++;
                last_ack = ackBit;
            end
            case (phase)
                0: if (cycleDone && i2cTransactionValid && !i2cBusy) begin
                    if (log_n < 256) begin
                        log_op[log_n]   = i2cCommand;
                        log_data[log_n] = i2cWriteData;
                    end
                    log_n++;
                    cur_op = i2cCommand;
                    phase  = 1;
                end
                1: begin
                    i2cBusy = 1'b1;
                    hold    = 0;
                    phase   = 2;
                end
                2: begin
                    hold++;
                    if (hold == 3) begin
                        if (cur_op == 2'b10) begin
                            i2cReadDataValid = 1'b1;
                            i2cReadData      = {7'd0, (tx_seen == nack_idx)};
                            tx_seen++;
                            phase = 3;
                        end else begin
                            i2cBusy = 1'b0;
                            phase   = 0;
                        end
                    end
                end
                default: begin
                    i2cReadDataValid = 1'b0;
                    i2cBusy          = 1'b0;
                    phase            = 0;
                end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [7:0] d);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdData  = d;
        step();
        cmdValid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        step();
        step();
        for (int i = 0; i < max_cyc; i++) begin
            if (!busy && (phase == 0) && !i2cBusy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        total++; if (cmdReady !== 1'b1) begin bad++; $display("FAIL reset_cmdReady: got %b want 1", cmdReady); end
        total++; if (fifoCount !== 4'd0) begin bad++; $display("FAIL reset_fifoCount: got %0d want 0", fifoCount); end
        total++; if (i2cTransactionValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", i2cTransactionValid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if ({ackValid, ackBit, nackError, opError} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {ackValid, ackBit, nackError, opError}); end
        total++; if ({i2cCommand, i2cWriteData, cycleDone} !== 11'd0) begin bad++; $display("FAIL reset_engine_outs: got %h want 0", {i2cCommand, i2cWriteData, cycleDone}); end
    endtask

    task automatic test_tick();
        divisor = 16'd3;
        enable  = 1'b1;
        #1;
        for (int i = 0; i < 12; i++) begin
            total++;
            if (cycleDone !== ((i % 4) == 3)) begin bad++; $display("FAIL tick_div3[%0d]: got %b want %b", i, cycleDone, ((i % 4) == 3)); end
            step();
        end
        divisor = 16'd0;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (cycleDone !== 1'b1) begin bad++; $display("FAIL tick_div0[%0d]: got %b want 1", i, cycleDone); end
            step();
        end
        enable = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (cycleDone !== 1'b0) begin bad++; $display("FAIL tick_disabled[%0d]: got %b want 0", i, cycleDone); end
            step();
        end
    endtask

    task automatic test_basic_ack();
        int base, abase;
        bit ok;
        divisor  = 16'd1;
        enable   = 1'b1;
        nack_idx = -1;
        base     = log_n;
        abase    = ack_cnt;
        push(2'b00, 8'h00);
        push(2'b10, 8'hA4);
        push(2'b01, 8'h00);
        wait_idle(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout: busy=%b want idle within budget", busy); end
        total++; if (log_n - base != 3) begin bad++; $display("FAIL basic_accepts: got %0d want 3", log_n - base); end
        total++; if (log_op[base] !== 2'b00) begin bad++; $display("FAIL basic_op0: got %b want 00", log_op[base]); end
        total++; if ({log_op[base+1], log_data[base+1]} !== 10'h2A4) begin bad++; $display("FAIL basic_tx: got %h want 2a4", {log_op[base+1], log_data[base+1]}); end
        total++; if (log_op[base+2] !== 2'b01) begin bad++; $display("FAIL basic_op2: got %b want 01", log_op[base+2]); end
        total++; if (ack_cnt - abase != 1) begin bad++; $display("FAIL basic_ackValid_count: got %0d want 1", ack_cnt - abase); end
        total++; if (last_ack !== 1'b0) begin bad++; $display("FAIL basic_ackBit: got %b want 0", last_ack); end
        total++; if (nackError !== 1'b0) begin bad++; $display("FAIL basic_nackError: got %b want 0", nackError); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_nack_flush();
        int base, abase;
        bit ok;
        nack_idx = tx_seen;
        base     = log_n;
        abase    = ack_cnt;
        push(2'b00, 8'h00);
        push(2'b10, 8'h50);
        push(2'b10, 8'h11);
        push(2'b01, 8'h00);
        wait_idle(400, ok);
        nack_idx = -1;
        total++; if (!ok) begin bad++; $display("FAIL nack_timeout: busy=%b want idle within budget", busy); end
        total++; if (nackError !== 1'b1) begin bad++; $display("FAIL nack_error: got %b want 1", nackError); end
        total++; if (fifoCount !== 4'd0) begin bad++; $display("FAIL nack_fifoCount: got %0d want 0", fifoCount); end
        total++; if (log_n - base != 3) begin bad++; $display("FAIL nack_accepts: got %0d want 3", log_n - base); end
        total++; if ({log_op[base+1], log_data[base+1]} !== 10'h250) begin bad++; $display("FAIL nack_tx: got %h want 250", {log_op[base+1], log_data[base+1]}); end
        total++; if (log_op[base+2] !== 2'b01) begin bad++; $display("FAIL nack_forced_stop: got %b want 01", log_op[base+2]); end
        total++; if (ack_cnt - abase != 1) begin bad++; $display("FAIL nack_ackValid_count: got %0d want 1", ack_cnt - abase); end
        total++; if (last_ack !== 1'b1) begin bad++; $display("FAIL nack_ackBit: got %b want 1", last_ack); end
        errorClear = 1'b1;
        step();
        errorClear = 1'b0;
        total++; if (nackError !== 1'b0) begin bad++; $display("FAIL nack_clear: got %b want 0", nackError); end
    endtask

    task automatic test_fifo_full();
        int base;
        bit ok;
        enable = 1'b0;
        base   = log_n;
        for (int i = 0; i < 8; i++) begin
            push(2'b01, 8'(i));
        end
        total++; if (cmdReady !== 1'b0) begin bad++; $display("FAIL full_cmdReady: got %b want 0", cmdReady); end
        total++; if (fifoCount !== 4'd8) begin bad++; $display("FAIL full_count: got %0d want 8", fifoCount); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy: got %b want 1", busy); end
        push(2'b01, 8'h08);
        total++; if (fifoCount !== 4'd8) begin bad++; $display("FAIL full_drop: got %0d want 8", fifoCount); end
        enable = 1'b1;
        wait_idle(800, ok);
        total++; if (!ok) begin bad++; $display("FAIL full_timeout: busy=%b want idle within budget", busy); end
        total++; if (log_n - base != 8) begin bad++; $display("FAIL full_drain_accepts: got %0d want 8", log_n - base); end
        total++; if (cmdReady !== 1'b1) begin bad++; $display("FAIL full_ready_after: got %b want 1", cmdReady); end
    endtask

    task automatic test_illegal_op();
        int base;
        bit ok;
        base = log_n;
        push(2'b11, 8'h77);
        push(2'b01, 8'h00);
        wait_idle(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL op11_timeout: busy=%b want idle within budget", busy); end
        total++; if (opError !== 1'b1) begin bad++; $display("FAIL op11_opError: got %b want 1", opError); end
        total++; if (log_n - base != 1) begin bad++; $display("FAIL op11_accepts: got %0d want 1", log_n - base); end
        total++; if (log_op[base] !== 2'b01) begin bad++; $display("FAIL op11_stop: got %b want 01", log_op[base]); end
        errorClear = 1'b1;
        step();
        errorClear = 1'b0;
        total++; if (opError !== 1'b0) begin bad++; $display("FAIL op11_clear: got %b want 0", opError); end
    endtask

    task automatic test_reset_mid_tx();
        int base, abase;
        bit ok, seen;
        abase = ack_cnt;
        push(2'b00, 8'h00);
        push(2'b10, 8'h33);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ((phase == 2) && (cur_op == 2'b10)) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        total++; if (!seen) begin bad++; $display("FAIL midreset_reach_tx: phase=%0d want 2", phase); end
        reset = 1'b1;
        #1;
        total++; if (fifoCount !== 4'd0) begin bad++; $display("FAIL midreset_count: got %0d want 0", fifoCount); end
        total++; if ({i2cTransactionValid, busy, ackValid, nackError, opError} !== 5'b0) begin bad++; $display("FAIL midreset_flags: got %b want 00000", {i2cTransactionValid, busy, ackValid, nackError, opError}); end
        total++; if ({cmdReady, i2cCommand, i2cWriteData, cycleDone} !== 12'h800) begin bad++; $display("FAIL midreset_outs: got %h want 800", {cmdReady, i2cCommand, i2cWriteData, cycleDone}); end
        step();
        step();
        reset = 1'b0;
        step();
        base = log_n;
        push(2'b01, 8'h00);
        wait_idle(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL midreset_timeout: busy=%b want idle within budget", busy); end
        total++; if ((log_n - base != 1) || (log_op[base] !== 2'b01)) begin bad++; $display("FAIL midreset_reissue: got n=%0d op=%b want n=1 op=01", log_n - base, log_op[base]); end
        total++; if (ack_cnt - abase != 0) begin bad++; $display("FAIL midreset_no_ack: got %0d want 0", ack_cnt - abase); end
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        divisor    = 16'd3;
        cmdValid   = 1'b0;
        cmdOp      = 2'b00;
        cmdData    = 8'h00;
        errorClear = 1'b0;
        step();
        step();
        test_reset();
        reset = 1'b0;
        step();
        test_tick();
        test_basic_ack();
        test_nack_flush();
        test_fifo_full();
        test_illegal_op();
        test_reset_mid_tx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
